// File: rtl/lc3_defs.sv
// Shared LC-3 controller definitions: opcodes, memory-access state encodings
// and opcode-class helpers used by the pipeline controller and its sub-blocks.
package lc3_defs;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OP_W-1:0] OP_STR = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OP_W-1:0] OP_STI = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OP_W-1:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_IND   = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_IDLE  = 2'd3
  } mem_state_e;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_ctrl(input logic [OP_W-1:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  // Loads that actually touch data memory (LEA only computes an address)
  function automatic logic is_load_mem(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic uses_sr1(input logic [OP_W-1:0] op);
    return is_alu(op) || (op == OP_LDR) || (op == OP_STR) || (op == OP_JMP);
  endfunction

  function automatic logic is_alu_reg(input logic [OP_W-1:0] op, input logic imm);
    return ((op == OP_ADD) || (op == OP_AND)) && !imm;
  endfunction

endpackage

// File: rtl/lc3_pipe_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface lc3_pipe_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;

  modport master (
    input  complete_instr, complete_data, IMem_dout, IR, IR_Exec, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );

  modport slave (
    output complete_instr, complete_data, IMem_dout, IR, IR_Exec, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );
endinterface

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer: tracks read / indirect / write phases of the
// instruction in Execute until data memory signals completion.
module lc3_mem_fsm
  import lc3_defs::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic            complete_data,
  output mem_state_e      state
);

  mem_state_e next_state;
  logic       ind_store;
  logic       ind_store_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MEM_IDLE;
      ind_store <= 1'b0;
    end else begin
      state     <= next_state;
      ind_store <= ind_store_next;
    end
  end

  // Remember LDI vs STI: the Execute IR may move on while the pointer is fetched
  always_comb begin
    next_state     = state;
    ind_store_next = ind_store;
    case (state)
      MEM_IDLE: begin
        if (start) begin
          if ((opcode == OP_LD) || (opcode == OP_LDR)) begin
            next_state = MEM_READ;
          end else if (opcode == OP_LDI) begin
            next_state     = MEM_IND;
            ind_store_next = 1'b0;
          end else if (opcode == OP_STI) begin
            next_state     = MEM_IND;
            ind_store_next = 1'b1;
          end else if ((opcode == OP_ST) || (opcode == OP_STR)) begin
            next_state = MEM_WRITE;
          end
        end
      end
      MEM_IND: begin
        if (complete_data) next_state = ind_store ? MEM_WRITE : MEM_READ;
      end
      MEM_READ, MEM_WRITE: begin
        if (complete_data) next_state = MEM_IDLE;
      end
      default: next_state = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 five-stage pipeline controller: stage enables, branch bubbles and
// decision, data-memory stall sequencing and Execute operand bypass selects.
module lc3_pipe_controller
  import lc3_defs::*;
#(
  parameter int unsigned BR_STALL_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  lc3_pipe_controller_if.master bus
);

  localparam int unsigned CNT_W = (BR_STALL_CYCLES < 2) ? 1 : $clog2(BR_STALL_CYCLES + 1);

  mem_state_e         mem_state;
  logic               mem_idle;
  logic               exec_en;
  logic [CNT_W-1:0]   br_count;
  logic [OP_W-1:0]    op_d;
  logic [OP_W-1:0]    op_x;
  logic [2:0]         dst_x;
  logic               match_1;
  logic               match_2;
  logic               taken;
  logic               unused_bits;

  assign op_d        = bus.IR[15:12];
  assign op_x        = bus.IR_Exec[15:12];
  assign dst_x       = bus.IR_Exec[11:9];
  assign mem_idle    = (mem_state == MEM_IDLE);
  assign exec_en     = !reset && mem_idle;
  assign unused_bits = ^{bus.IR[4:3], bus.IR_Exec[8:0]};

  lc3_mem_fsm u_mem_fsm (
    .clock         (clock),
    .reset         (reset),
    .start         (exec_en),
    .opcode        (op_x),
    .complete_data (bus.complete_data),
    .state         (mem_state)
  );

  // Fetch-bubble counter; frozen while a data access holds the pipe
  always_ff @(posedge clock) begin
    if (reset) begin
      br_count <= '0;
    end else if (mem_idle) begin
      if (br_count != '0) begin
        br_count <= br_count - CNT_W'(1);
      end else if (bus.complete_instr && is_ctrl(bus.IMem_dout[15:12])) begin
        br_count <= CNT_W'(BR_STALL_CYCLES);
      end
    end
  end

  assign match_1 = uses_sr1(op_d) && (bus.IR[8:6] == dst_x);
  assign match_2 = (is_alu_reg(op_d, bus.IR[5]) && (bus.IR[2:0] == dst_x)) ||
                   (is_store(op_d) && (bus.IR[11:9] == dst_x));
  assign taken   = (br_count == CNT_W'(1)) && is_ctrl(op_x) && |(bus.NZP & bus.psr);

  always_comb begin
    bus.enable_updatePC  = 1'b0;
    bus.enable_fetch     = 1'b0;
    bus.enable_decode    = 1'b0;
    bus.enable_execute   = 1'b0;
    bus.enable_writeback = 1'b0;
    bus.br_taken         = 1'b0;
    bus.mem_state        = 2'(MEM_IDLE);
    bus.bypass_alu_1     = 1'b0;
    bus.bypass_alu_2     = 1'b0;
    bus.bypass_mem_1     = 1'b0;
    bus.bypass_mem_2     = 1'b0;
    if (!reset) begin
      bus.mem_state        = 2'(mem_state);
      bus.enable_execute   = mem_idle;
      bus.enable_decode    = mem_idle && bus.complete_instr;
      bus.enable_fetch     = mem_idle && bus.complete_instr && (br_count == '0);
      bus.br_taken         = mem_idle && taken;
      bus.enable_updatePC  = bus.enable_fetch || bus.br_taken;
      bus.enable_writeback = mem_idle || ((mem_state == MEM_READ) && bus.complete_data);
      if (mem_idle) begin
        bus.bypass_mem_1 = is_load_mem(op_x) && match_1;
        bus.bypass_mem_2 = is_load_mem(op_x) && match_2;
        bus.bypass_alu_1 = is_alu(op_x) && match_1 && !bus.bypass_mem_1;
        bus.bypass_alu_2 = is_alu(op_x) && match_2 && !bus.bypass_mem_2;
      end
    end
  end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Self-checking bench for lc3_pipe_controller: vector table plus hand-built
// multi-cycle sequences, expectations queued at drive time and checked mid-cycle.
module tb_lc3_pipe_controller;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  lc3_pipe_controller_if bus ();

  lc3_pipe_controller #(.BR_STALL_CYCLES(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Expected word: {updatePC, fetch, decode, execute, writeback, br_taken,
  //                 mem_state[1:0], alu_1, alu_2, mem_1, mem_2}
  typedef struct {
    string       name;
    logic        rst;
    logic        ci;
    logic        cd;
    logic [15:0] imem;
    logic [15:0] ir;
    logic [15:0] irx;
    logic [2:0]  nzp;
    logic [2:0]  psr;
    logic [11:0] exp;
  } vec_t;

  localparam logic [15:0] ADD123 = 16'h1283;  // ADD R1,R2,R3
  localparam logic [15:0] ADD411 = 16'h1841;  // ADD R4,R1,R1
  localparam logic [15:0] ADD567 = 16'h1B87;  // ADD R5,R6,R7
  localparam logic [15:0] ADDIMM = 16'h18A1;  // ADD R4,R2,#1
  localparam logic [15:0] ADD422 = 16'h1882;  // ADD R4,R2,R2
  localparam logic [15:0] AND1   = 16'h5283;  // AND R1,R2,R3
  localparam logic [15:0] NOT41  = 16'h9841;  // NOT R4,R1 (low bits 001)
  localparam logic [15:0] JMPR1  = 16'hC040;  // JMP R1
  localparam logic [15:0] LD5    = 16'h2A00;  // LD R5
  localparam logic [15:0] LDR2   = 16'h64C0;  // LDR R2,R3,#0
  localparam logic [15:0] LEA1   = 16'hE200;  // LEA R1
  localparam logic [15:0] LDI2   = 16'hA400;  // LDI R2
  localparam logic [15:0] STR5   = 16'h7A42;  // STR R5,R1,#2
  localparam logic [15:0] BRZ    = 16'h0405;  // BRz

  localparam logic [11:0] E_RUN  = 12'b111110_11_0000;
  localparam logic [11:0] E_RST  = 12'b000000_11_0000;
  localparam logic [11:0] E_BUB  = 12'b001110_11_0000;
  localparam logic [11:0] E_RDC  = 12'b000010_00_0000;

  logic [11:0] exp_q[$];
  string       name_q[$];
  vec_t        tbl[$];
  int          tests = 0;
  int          fails = 0;

  function automatic vec_t mk(input string n, input logic rst, input logic ci, input logic cd,
                              input logic [15:0] imem, input logic [15:0] ir,
                              input logic [15:0] irx, input logic [2:0] nzp,
                              input logic [2:0] psr, input logic [11:0] e);
    vec_t v;
    v.name = n; v.rst = rst; v.ci = ci; v.cd = cd; v.imem = imem;
    v.ir = ir; v.irx = irx; v.nzp = nzp; v.psr = psr; v.exp = e;
    return v;
  endfunction

  task automatic check_out();
    logic [11:0] got;
    logic [11:0] e;
    string       n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    got = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode, bus.enable_execute,
           bus.enable_writeback, bus.br_taken, bus.mem_state,
           bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2};
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s: got %b required %b", n, got, e);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clock);
    #1;
    reset              = v.rst;
    bus.complete_instr = v.ci;
    bus.complete_data  = v.cd;
    bus.IMem_dout      = v.imem;
    bus.IR             = v.ir;
    bus.IR_Exec        = v.irx;
    bus.NZP            = v.nzp;
    bus.psr            = v.psr;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clock);
    check_out();
  endtask

  initial begin
    reset              = 1'b1;
    bus.complete_instr = 1'b1;
    bus.complete_data  = 1'b0;
    bus.IMem_dout      = ADD123;
    bus.IR             = ADD123;
    bus.IR_Exec        = ADD123;
    bus.NZP            = 3'b000;
    bus.psr            = 3'b000;

    tbl.push_back(mk("reset",        1, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RST));
    tbl.push_back(mk("first_run",    0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));
    tbl.push_back(mk("alu_byp_both", 0, 1, 0, ADD123, ADD411, ADD123, 3'b000, 3'b000, 12'b111110_11_1100));
    tbl.push_back(mk("mem_byp_str",  0, 1, 0, ADD123, STR5,   LD5,    3'b000, 3'b000, 12'b111110_11_0001));
    tbl.push_back(mk("ld_read_done", 0, 1, 1, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RDC));
    tbl.push_back(mk("ld_back_idle", 0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));
    tbl.push_back(mk("lea_no_byp",   0, 1, 0, ADD123, ADD411, LEA1,   3'b000, 3'b000, E_RUN));
    tbl.push_back(mk("lea_no_access",0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));
    tbl.push_back(mk("and_jmp_sr1",  0, 1, 0, ADD123, JMPR1,  AND1,   3'b000, 3'b000, 12'b111110_11_1000));
    tbl.push_back(mk("not_no_sr2",   0, 1, 0, ADD123, NOT41,  ADD123, 3'b000, 3'b000, 12'b111110_11_1000));
    tbl.push_back(mk("imm_no_sr2",   0, 1, 0, ADD123, ADDIMM, ADD123, 3'b000, 3'b000, E_RUN));
    tbl.push_back(mk("instr_stall",  0, 0, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000110_11_0000));
    tbl.push_back(mk("ldr_byp_both", 0, 1, 0, ADD123, ADD422, LDR2,   3'b000, 3'b000, 12'b111110_11_0011));
    tbl.push_back(mk("ldr_read_done",0, 1, 1, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RDC));
    tbl.push_back(mk("ldr_idle",     0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));
    foreach (tbl[i]) apply(tbl[i]);

    // LDI: indirect phase completes after 2 cycles, read after 3
    apply(mk("ldi_start",  0, 1, 0, ADD123, ADD567, LDI2,   3'b000, 3'b000, E_RUN));
    apply(mk("ldi_ind_w",  0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000000_01_0000));
    apply(mk("ldi_ind_c",  0, 1, 1, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000000_01_0000));
    apply(mk("ldi_rd_w1",  0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000000_00_0000));
    apply(mk("ldi_rd_w2",  0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000000_00_0000));
    apply(mk("ldi_rd_c",   0, 1, 1, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RDC));
    apply(mk("ldi_idle",   0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));

    // STR: write phase, no writeback pulse on completion
    apply(mk("str_start",  0, 1, 0, ADD123, ADD123, STR5,   3'b000, 3'b000, E_RUN));
    apply(mk("str_wr_w",   0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000000_10_0000));
    apply(mk("str_wr_c",   0, 1, 1, ADD123, ADD123, ADD123, 3'b000, 3'b000, 12'b000000_10_0000));
    apply(mk("str_idle",   0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));

    // BRz taken: three fetch bubbles, decision in the last one
    apply(mk("brt_fetch",  0, 1, 0, BRZ,    ADD123, ADD123, 3'b000, 3'b000, E_RUN));
    apply(mk("brt_bub3",   0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_BUB));
    apply(mk("brt_bub2",   0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_BUB));
    apply(mk("brt_taken",  0, 1, 0, ADD123, ADD123, BRZ,    3'b010, 3'b010, 12'b101111_11_0000));
    apply(mk("brt_resume", 0, 1, 0, ADD123, ADD123, ADD123, 3'b010, 3'b010, E_RUN));

    // BRz not taken; BR word held on IMem must not re-arm the counter
    apply(mk("brn_fetch",  0, 1, 0, BRZ,    ADD123, ADD123, 3'b000, 3'b100, E_RUN));
    apply(mk("brn_bub3",   0, 1, 0, BRZ,    ADD123, ADD123, 3'b000, 3'b100, E_BUB));
    apply(mk("brn_bub2",   0, 1, 0, BRZ,    ADD123, ADD123, 3'b000, 3'b100, E_BUB));
    apply(mk("brn_decide", 0, 1, 0, BRZ,    ADD123, BRZ,    3'b010, 3'b100, E_BUB));
    apply(mk("brn_resume", 0, 1, 0, ADD123, ADD123, ADD123, 3'b010, 3'b100, E_RUN));

    // Reset in the middle of an indirect access
    apply(mk("rst_ldi",    0, 1, 0, ADD123, ADD567, LDI2,   3'b000, 3'b000, E_RUN));
    apply(mk("rst_assert", 1, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RST));
    apply(mk("rst_hold",   1, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RST));
    apply(mk("rst_release",0, 1, 0, ADD123, ADD123, ADD123, 3'b000, 3'b000, E_RUN));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_controller.md
Name: lc3_pipe_controller

Overview:
- Central pipeline controller for the LC-3 five-stage pipeline (Fetch, Decode, Execute, MemAccess, Writeback).
- Generates per-stage enables, the branch-taken decision, the data-memory access state machine, and operand bypass selects for the Execute stage.
- Sits beside the datapath. Watches the fetched word, the Decode and Execute IRs, NZP from Execute and PSR from Writeback.

Parameters:
- BR_STALL_CYCLES, 3, number of fetch-bubble cycles inserted after a control instruction is fetched.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- complete_instr  input  1  instruction memory has returned a valid word
- complete_data  input  1  data memory has completed the current access
- IMem_dout  input  16  word currently returned by instruction memory
- IR  input  16  instruction held in Decode (feeding Execute)
- IR_Exec  input  16  instruction currently in Execute
- NZP  input  3  branch condition mask registered by Execute
- psr  input  3  current N/Z/P flags from Writeback
- enable_updatePC  output  1  PC register update enable
- enable_fetch  output  1  Fetch stage enable
- enable_decode  output  1  Decode stage enable
- enable_execute  output  1  Execute stage enable
- enable_writeback  output  1  Writeback stage enable
- br_taken  output  1  PC loads branch target instead of PC+1
- mem_state  output  2  data-memory access state (0 read, 1 indirect read, 2 write, 3 idle)
- bypass_alu_1  output  1  Execute operand 1 from previous ALU result
- bypass_alu_2  output  1  Execute operand 2 from previous ALU result
- bypass_mem_1  output  1  Execute operand 1 from memory read data
- bypass_mem_2  output  1  Execute operand 2 from memory read data

Behaviour:
- Reset value of every output while reset is high: enables 0, br_taken 0, mem_state 3, bypasses 0, internal stall counter 0.
- First cycle after reset: all enables 1.
- Opcode classes, IR[15:12]:
  - ALU: 0001, 0101, 1001
  - control: 0000, 1100
  - load: 0010, 0110, 1010, 1110 (LEA needs no memory access)
  - store: 0011, 0111, 1011
- mem_state FSM, registered:
  - IDLE(3) to READ(0) when enable_execute and IR_Exec is LD or LDR.
  - IDLE to INDIRECT(1) for LDI or STI.
  - IDLE to WRITE(2) for ST or STR.
  - INDIRECT stays until complete_data, then goes to READ (LDI) or WRITE (STI).
  - READ and WRITE stay until complete_data, then return to IDLE.
- Memory stall: while mem_state != 3, fetch/decode/execute/updatePC are 0. enable_writeback is 0 except in the cycle READ completes.
- Instruction stall: complete_instr low forces enable_fetch, enable_decode and enable_updatePC to 0. Execute and writeback are unaffected.
- Control hazard:
  - When IMem_dout is a control op and complete_instr is high, load the counter with BR_STALL_CYCLES.
  - While the counter is nonzero, enable_updatePC and enable_fetch are 0; the counter decrements each cycle.
  - A new control op is not recognised while the counter is nonzero.
- Branch decision:
  - br_taken = 1 for one cycle when IR_Exec is control and |(NZP & psr), sampled when the counter equals 1.
  - In that cycle enable_updatePC is forced to 1.
  - JMP always yields NZP=111, so it is always taken.
- Bypass, combinational from IR and IR_Exec:
  - bypass_alu_1: IR_Exec is ALU and IR_Exec[11:9]==IR[8:6], and IR uses sr1 (ALU, LDR, STR, JMP).
  - bypass_alu_2: IR_Exec is ALU and either IR is ALU register-mode (IR[5]==0, not NOT) with IR[2:0]==IR_Exec[11:9], or IR is a store with IR[11:9]==IR_Exec[11:9].
  - bypass_mem_1/2: same match rules with IR_Exec a load other than LEA. The alu bypasses are 0 when the mem bypasses are 1.
  - All bypasses are 0 when enable_execute is 0.
- Simultaneous events:
  - A memory stall dominates the branch counter; the counter freezes while mem_state != 3.
  - reset mid-access returns mem_state to 3 next cycle.

Decomposition:
- Shared package lc3_defs holds:
  - opcode constants
  - mem_state encodings (MEM_READ=0, MEM_IND=1, MEM_WRITE=2, MEM_IDLE=3)
  - opcode-class helper functions
- One natural sub-module: lc3_mem_fsm (mem_state register plus completion logic). Bypass and stall logic stay in the top module.

Test Plan:
- Reset then release, ADD R1,R2,R3 stream with complete_instr=1 -> all enables 1 from cycle 1, mem_state=3, bypasses 0.
- ADD R1,R2,R3 then ADD R4,R1,R1 -> bypass_alu_1=1 and bypass_alu_2=1 in the cycle the second ADD is in Decode.
- LDI R2 in Execute, complete_data after 2 cycles, then after 3 -> mem_state 3→1→0→3, writeback pulse only at READ completion, other enables 0 throughout.
- STR R5,R1,#2 -> mem_state 3→2→3 after complete_data; enable_writeback stays 0.
- BRz with psr=010, NZP=010 -> 3-cycle fetch stall then br_taken=1 for one cycle; repeat with psr=100 -> br_taken=0.
- Assert reset while mem_state=1 -> next cycle mem_state=3 and all outputs at reset values.
